// File: rtl/intc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | intc_pkg : shared constants and helpers for the int_ctrl slice    |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
package intc_pkg;

  localparam logic [1:0] c_st_idle       = 2'd0;
  localparam logic [1:0] c_st_dispatch   = 2'd1;
  localparam logic [1:0] c_st_in_service = 2'd2;
  localparam logic [1:0] c_st_return     = 2'd3;

  localparam logic [31:0] c_vec_base  = 32'h0000_0100;
  localparam int          c_vec_shift = 4;

  // A single source still needs a 1-bit index.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_enc_lsb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prio_enc_lsb : combinational priority encoder, lowest index wins  |
// | Rev 1.0      : initial release                                    |
// +------------------------------------------------------------------+
module prio_enc_lsb
  import intc_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan downward so the last hit written is the lowest set index.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | int_ctrl : edge-latched, masked, non-nesting interrupt controller |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
module int_ctrl
  import intc_pkg::*;
#(
  parameter int               N_SRC     = 4,
  parameter logic [31:0]      VEC_BASE  = c_vec_base,
  parameter int               VEC_SHIFT = c_vec_shift,
  parameter logic [N_SRC-1:0] MASK_RST  = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           irq_src,
  input  logic                       eret,
  input  logic                       mask_we,
  input  logic [N_SRC-1:0]           mask_wd,
  output logic                       irq,
  output logic [31:0]                EAddr,
  output logic                       iack,
  output logic                       in_service,
  output logic [id_width(N_SRC)-1:0] active_id,
  output logic [N_SRC-1:0]           pending,
  output logic [N_SRC-1:0]           mask
);

  localparam int ID_W = id_width(N_SRC);

  logic [1:0]       r_state;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic             r_irq;
  logic             r_iack;
  logic             r_in_service;
  logic [ID_W-1:0]  r_active_id;
  logic [31:0]      r_eaddr;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_clr;
  logic             w_valid;
  logic [ID_W-1:0]  w_idx;
  logic             w_dispatch;
  logic [31:0]      w_vec;

  prio_enc_lsb #(
    .N  (N_SRC),
    .IW (ID_W)
  ) u_prio (
    .req   (r_pending & r_mask),
    .valid (w_valid),
    .idx   (w_idx)
  );

  assign w_rise     = irq_src & ~r_prev;
  assign w_dispatch = (r_state == c_st_idle) && w_valid;
  assign w_clr      = w_dispatch ? (N_SRC'(1) << w_idx) : '0;
  assign w_vec      = VEC_BASE + (32'(w_idx) << VEC_SHIFT);

  // A fresh edge OR-ed in after the clear lets a coincident rise survive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_mask    <= MASK_RST;
    end else begin
      r_prev    <= irq_src;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) begin
        r_mask <= mask_wd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_irq        <= 1'b0;
      r_iack       <= 1'b0;
      r_in_service <= 1'b0;
      r_active_id  <= '0;
      r_eaddr      <= VEC_BASE;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_dispatch) begin
            r_state      <= c_st_dispatch;
            r_irq        <= 1'b1;
            r_in_service <= 1'b1;
            r_active_id  <= w_idx;
            r_eaddr      <= w_vec;
          end
        end
        c_st_dispatch: begin
          r_state <= c_st_in_service;
          r_irq   <= 1'b0;
        end
        c_st_in_service: begin
          if (eret) begin
            r_state <= c_st_return;
            r_iack  <= 1'b1;
          end
        end
        c_st_return: begin
          r_state      <= c_st_idle;
          r_iack       <= 1'b0;
          r_in_service <= 1'b0;
        end
        default: begin
          r_state      <= c_st_idle;
          r_irq        <= 1'b0;
          r_iack       <= 1'b0;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  assign irq        = r_irq;
  assign iack       = r_iack;
  assign in_service = r_in_service;
  assign active_id  = r_active_id;
  assign EAddr      = r_eaddr;
  assign pending    = r_pending;
  assign mask       = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_int_ctrl : vector-table bench for int_ctrl (N_SRC=4)           |
// | Rev 1.0     : initial release                                     |
// +------------------------------------------------------------------+
module tb_int_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_src;
  logic        eret;
  logic        mask_we;
  logic [3:0]  mask_wd;
  logic        irq;
  logic [31:0] EAddr;
  logic        iack;
  logic        in_service;
  logic [1:0]  active_id;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int checks   = 0;
  int failures = 0;

  int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .eret       (eret),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .irq        (irq),
    .EAddr      (EAddr),
    .iack       (iack),
    .in_service (in_service),
    .active_id  (active_id),
    .pending    (pending),
    .mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // em = {eret, mask_we}; flg = expected {irq, iack, in_service}
  typedef struct {
    logic [3:0]  src;
    logic [1:0]  em;
    logic [3:0]  mwd;
    logic [2:0]  flg;
    logic [1:0]  aid;
    logic [3:0]  pend;
    logic [3:0]  msk;
    logic [31:0] addr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] src, input logic [1:0] em, input logic [3:0] mwd,
                     input logic [2:0] flg, input logic [1:0] aid, input logic [3:0] pend,
                     input logic [3:0] msk, input logic [31:0] addr);
    vec_t v;
    v.src = src; v.em = em; v.mwd = mwd; v.flg = flg;
    v.aid = aid; v.pend = pend; v.msk = msk; v.addr = addr;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Protocol watchdog: irq/iack exclusive, no second irq before an iack.
  bit seen_irq = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      seen_irq = 1'b0;
    end else begin
      checks++;
      if ((irq && iack) || (irq && seen_irq)) begin
        failures++;
        $display("FAIL protocol: irq=%0b iack=%0b seen_irq=%0b", irq, iack, seen_irq);
      end
      if (irq) seen_irq = 1'b1;
      if (iack) seen_irq = 1'b0;
    end
  end

  initial begin
    bit got;
    rst = 1'b1; irq_src = '0; eret = 1'b0; mask_we = 1'b0; mask_wd = '0;

    // single source, then simultaneous sources 1 and 3
    add(4'h4, 2'b00, 4'h0, 3'b000, 2'd0, 4'h4, 4'hF, 32'h100);
    add(4'h0, 2'b00, 4'h0, 3'b101, 2'd2, 4'h0, 4'hF, 32'h120);
    add(4'h0, 2'b00, 4'h0, 3'b001, 2'd2, 4'h0, 4'hF, 32'h120);
    add(4'h0, 2'b10, 4'h0, 3'b011, 2'd2, 4'h0, 4'hF, 32'h120);
    add(4'h0, 2'b00, 4'h0, 3'b000, 2'd2, 4'h0, 4'hF, 32'h120);
    add(4'hA, 2'b00, 4'h0, 3'b000, 2'd2, 4'hA, 4'hF, 32'h120);
    add(4'h0, 2'b00, 4'h0, 3'b101, 2'd1, 4'h8, 4'hF, 32'h110);
    add(4'h0, 2'b00, 4'h0, 3'b001, 2'd1, 4'h8, 4'hF, 32'h110);
    add(4'h0, 2'b10, 4'h0, 3'b011, 2'd1, 4'h8, 4'hF, 32'h110);
    add(4'h0, 2'b00, 4'h0, 3'b000, 2'd1, 4'h8, 4'hF, 32'h110);
    add(4'h0, 2'b00, 4'h0, 3'b101, 2'd3, 4'h0, 4'hF, 32'h130);
    add(4'h0, 2'b00, 4'h0, 3'b001, 2'd3, 4'h0, 4'hF, 32'h130);
    add(4'h0, 2'b10, 4'h0, 3'b011, 2'd3, 4'h0, 4'hF, 32'h130);
    add(4'h0, 2'b00, 4'h0, 3'b000, 2'd3, 4'h0, 4'hF, 32'h130);
    // masked source 0, unmask uses old mask in the write cycle
    add(4'h0, 2'b01, 4'hE, 3'b000, 2'd3, 4'h0, 4'hE, 32'h130);
    add(4'h1, 2'b00, 4'h0, 3'b000, 2'd3, 4'h1, 4'hE, 32'h130);
    add(4'h1, 2'b00, 4'h0, 3'b000, 2'd3, 4'h1, 4'hE, 32'h130);
    add(4'h0, 2'b01, 4'hF, 3'b000, 2'd3, 4'h1, 4'hF, 32'h130);
    add(4'h0, 2'b00, 4'h0, 3'b101, 2'd0, 4'h0, 4'hF, 32'h100);
    add(4'h0, 2'b00, 4'h0, 3'b001, 2'd0, 4'h0, 4'hF, 32'h100);
    // request during service waits for iack plus one idle cycle
    add(4'h2, 2'b00, 4'h0, 3'b001, 2'd0, 4'h2, 4'hF, 32'h100);
    add(4'h0, 2'b00, 4'h0, 3'b001, 2'd0, 4'h2, 4'hF, 32'h100);
    add(4'h0, 2'b10, 4'h0, 3'b011, 2'd0, 4'h2, 4'hF, 32'h100);
    add(4'h0, 2'b00, 4'h0, 3'b000, 2'd0, 4'h2, 4'hF, 32'h100);
    add(4'h0, 2'b00, 4'h0, 3'b101, 2'd1, 4'h0, 4'hF, 32'h110);
    // eret ignored in DISPATCH, RETURN and IDLE
    add(4'h0, 2'b10, 4'h0, 3'b001, 2'd1, 4'h0, 4'hF, 32'h110);
    add(4'h0, 2'b00, 4'h0, 3'b001, 2'd1, 4'h0, 4'hF, 32'h110);
    add(4'h0, 2'b10, 4'h0, 3'b011, 2'd1, 4'h0, 4'hF, 32'h110);
    add(4'h0, 2'b10, 4'h0, 3'b000, 2'd1, 4'h0, 4'hF, 32'h110);
    add(4'h0, 2'b10, 4'h0, 3'b000, 2'd1, 4'h0, 4'hF, 32'h110);
    // held level dispatches once
    add(4'h1, 2'b00, 4'h0, 3'b000, 2'd1, 4'h1, 4'hF, 32'h110);
    add(4'h1, 2'b00, 4'h0, 3'b101, 2'd0, 4'h0, 4'hF, 32'h100);
    add(4'h1, 2'b00, 4'h0, 3'b001, 2'd0, 4'h0, 4'hF, 32'h100);
    add(4'h1, 2'b10, 4'h0, 3'b011, 2'd0, 4'h0, 4'hF, 32'h100);
    add(4'h1, 2'b00, 4'h0, 3'b000, 2'd0, 4'h0, 4'hF, 32'h100);
    add(4'h1, 2'b00, 4'h0, 3'b000, 2'd0, 4'h0, 4'hF, 32'h100);
    // new edge coinciding with the dispatch clear keeps pending set
    add(4'h0, 2'b01, 4'hE, 3'b000, 2'd0, 4'h0, 4'hE, 32'h100);
    add(4'h1, 2'b00, 4'h0, 3'b000, 2'd0, 4'h1, 4'hE, 32'h100);
    add(4'h0, 2'b01, 4'hF, 3'b000, 2'd0, 4'h1, 4'hF, 32'h100);
    add(4'h1, 2'b00, 4'h0, 3'b101, 2'd0, 4'h1, 4'hF, 32'h100);
    add(4'h0, 2'b00, 4'h0, 3'b001, 2'd0, 4'h1, 4'hF, 32'h100);
    add(4'h0, 2'b10, 4'h0, 3'b011, 2'd0, 4'h1, 4'hF, 32'h100);
    add(4'h0, 2'b00, 4'h0, 3'b000, 2'd0, 4'h1, 4'hF, 32'h100);
    add(4'h0, 2'b00, 4'h0, 3'b101, 2'd0, 4'h0, 4'hF, 32'h100);
    add(4'h0, 2'b00, 4'h0, 3'b001, 2'd0, 4'h0, 4'hF, 32'h100);
    add(4'h4, 2'b00, 4'h0, 3'b001, 2'd0, 4'h4, 4'hF, 32'h100);

    repeat (2) @(posedge clk);
    #1;
    chk("reset irq",        32'(irq),        32'd0);
    chk("reset iack",       32'(iack),       32'd0);
    chk("reset in_service", 32'(in_service), 32'd0);
    chk("reset active_id",  32'(active_id),  32'd0);
    chk("reset pending",    32'(pending),    32'd0);
    chk("reset mask",       32'(mask),       32'hF);
    chk("reset EAddr",      EAddr,           32'h100);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      irq_src = vq[i].src;
      eret    = vq[i].em[1];
      mask_we = vq[i].em[0];
      mask_wd = vq[i].mwd;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d irq", i),        32'(irq),        32'(vq[i].flg[2]));
      chk($sformatf("row%0d iack", i),       32'(iack),       32'(vq[i].flg[1]));
      chk($sformatf("row%0d in_service", i), 32'(in_service), 32'(vq[i].flg[0]));
      chk($sformatf("row%0d active_id", i),  32'(active_id),  32'(vq[i].aid));
      chk($sformatf("row%0d pending", i),    32'(pending),    32'(vq[i].pend));
      chk($sformatf("row%0d mask", i),       32'(mask),       32'(vq[i].msk));
      chk($sformatf("row%0d EAddr", i),      EAddr,           vq[i].addr);
    end

    // Asynchronous reset while in service, source 3 held high through it.
    @(negedge clk);
    eret = 1'b0; mask_we = 1'b0;
    rst = 1'b1; irq_src = 4'h8;
    #1;
    chk("async rst in_service", 32'(in_service), 32'd0);
    chk("async rst pending",    32'(pending),     32'd0);
    chk("async rst iack",       32'(iack),        32'd0);
    chk("async rst EAddr",      EAddr,            32'h100);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst pending", 32'(pending), 32'h8);
    chk("post-rst irq",     32'(irq),     32'd0);
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-rst iack c%0d", c), 32'(iack), 32'd0);
      if (irq) got = 1'b1;
    end
    chk("post-rst irq seen", 32'(got),       32'd1);
    chk("post-rst EAddr",    EAddr,          32'h130);
    chk("post-rst active",   32'(active_id), 32'd3);
    @(negedge clk);
    @(negedge clk);
    eret = 1'b1;
    @(posedge clk);
    #1;
    chk("final iack", 32'(iack), 32'd1);
    @(negedge clk);
    eret = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt controller that drives the CPU datapath's exception interface.
- Latches rising edges on peripheral request lines and applies a mask.
- Picks the highest-priority pending source and issues a one-cycle irq with a vector address (EAddr).
- Tracks the in-service interrupt. When the control unit decodes an exception return, it issues a one-cycle iack so the PC is restored from the EPC.
- Sits between the peripherals and the single-cycle datapath. The datapath has one EPC register, so interrupts do not nest.

Parameters:
N_SRC, 4, number of interrupt request inputs (1..16)
VEC_BASE, 32'h0000_0100, vector address of source 0
VEC_SHIFT, 4, log2 byte stride between vectors
MASK_RST, all ones (N_SRC bits), mask register reset value (1 = enabled)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
irq_src  input  N_SRC  peripheral request levels, synchronous to clk
eret  input  1  one-cycle pulse from the control unit on an exception-return instruction
mask_we  input  1  mask register write enable
mask_wd  input  N_SRC  mask write data
irq  output  1  one-cycle interrupt request to the datapath
EAddr  output  32  vector address; valid while irq=1 and held afterwards
iack  output  1  one-cycle return strobe to the datapath (PC restored from EPC)
in_service  output  1  high from the irq cycle through the iack cycle
active_id  output  clog2(N_SRC) (minimum 1)  index of the source being serviced
pending  output  N_SRC  latched edge requests not yet dispatched
mask  output  N_SRC  current mask register

Behaviour:
Reset (asynchronous):
- irq=0, iack=0, in_service=0, active_id=0, pending=0, EAddr=VEC_BASE, mask=MASK_RST, state=IDLE.
- The previous-sample register for edge detection resets to 0. A source that is already high at reset release therefore latches as pending on the first edge.
- Reset mid-service drops all state. No iack is issued.

Edge capture:
- pending[i] is set at the clk edge where irq_src[i]=1 and its previous sample was 0.
- pending[i] is cleared at the edge that dispatches source i.
- If a new edge on source i coincides with its clear, set wins and pending[i] stays 1.

Priority:
- Eligible set is pending & mask. The lowest index wins.
- A masked pending bit stays latched and dispatches once it is unmasked.

Mask writes:
- mask_we updates mask at the edge.
- A dispatch decided in the same cycle uses the old mask.

FSM (registered outputs):
- IDLE: if the eligible set is non-zero, go to DISPATCH. On that edge load active_id, set EAddr = VEC_BASE + (idx << VEC_SHIFT), and clear pending[idx].
- DISPATCH: irq=1 for exactly this cycle, in_service=1. Go to IN_SERVICE unconditionally.
- IN_SERVICE: irq=0, in_service=1. When eret=1, go to RETURN.
- RETURN: iack=1 for exactly this cycle, in_service=1. Go to IDLE. No dispatch decision is made in this cycle.
- eret is ignored in IDLE, DISPATCH and RETURN.

Latency:
- irq_src rises before edge k, so pending=1 after edge k and irq=1 after edge k+1.
- eret sampled at edge m gives iack=1 after edge m.
- The earliest next irq comes 2 cycles after iack deasserts: IDLE for one cycle, then DISPATCH.

Invariants:
- irq and iack are never high in the same cycle.
- irq is never high twice without an intervening iack.
- EAddr does not change outside the IDLE→DISPATCH edge.

Decomposition:
- Shared package intc_pkg holds:
  - the state enum (IDLE, DISPATCH, IN_SERVICE, RETURN)
  - the default VEC_BASE and VEC_SHIFT constants
  - a clog2-based ID width function.
- One sub-module, prio_enc_lsb: combinational lowest-index-first priority encoder with parameter N. Outputs valid and index.
- Edge latch, mask register and FSM stay in int_ctrl.

Test Plan:
- Reset with irq_src=0 → irq=0, iack=0, EAddr=0x100, mask=4'b1111. Raise irq_src[2] for one cycle → pending=4'b0100 next cycle. The cycle after that: irq=1 for one cycle, EAddr=0x120, active_id=2, pending=0.
- irq_src[3] and irq_src[1] rise together → source 1 dispatched first (EAddr=0x110). Pulse eret → iack=1 for one cycle. Two cycles later source 3 dispatches with EAddr=0x130.
- Write mask=4'b1110, then raise irq_src[0] → pending[0]=1 and no irq. Write mask=4'b1111 → irq 2 cycles after the write with EAddr=0x100.
- During IN_SERVICE raise irq_src[1] → pending[1]=1 and no second irq. eret → iack; irq for source 1 follows only after iack, and never in the iack cycle.
- Hold irq_src[0] high continuously → exactly one dispatch, no re-trigger until the signal falls and rises again. A new edge in the dispatch cycle keeps pending[0]=1.
- Assert rst in IN_SERVICE → in_service=0, pending=0, iack never asserted. eret pulses in IDLE → no iack.
